// File: rtl/prm_load_seq.sv
// Parameter-memory load sequencer: walks an AXI-stream filter-major into per-core
// weight/bias memories, emitting a registered write strobe, core select, address and data.
module prm_load_seq #(
  parameter int f_num = 16,
  parameter int AW    = 10,
  parameter int DW    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     bmode,
  input  logic [3:0]               od,
  input  logic [AW-1:0]            fs,
  input  logic                     src_valid,
  input  logic [31:0]              src_data,
  input  logic                     src_last,
  output logic                     src_ready,
  output logic                     prm_we,
  output logic [$clog2(f_num)-1:0] prm_v,
  output logic [AW-1:0]            prm_a,
  output logic [DW-1:0]            prm_d,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [1:0]               dbg_state
);

  localparam int VW = $clog2(f_num);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [3:0]      r_od, w_od_nxt;
  logic [AW-1:0]   r_fs_eff, w_fs_eff_nxt;
  logic [VW-1:0]   r_fc, w_fc_nxt;
  logic [AW-1:0]   r_ac, w_ac_nxt;
  logic            r_err, w_err_nxt;
  logic            r_done, w_done_nxt;
  logic            r_we, w_we_nxt;
  logic [VW-1:0]   r_v, w_v_nxt;
  logic [AW-1:0]   r_a, w_a_nxt;
  logic [DW-1:0]   r_d, w_d_nxt;
  logic            w_hs;
  logic            w_final;
  logic            w_unused;

  // Handshake: a beat transfers on any cycle where src_valid and src_ready are both high.
  // src_ready is a pure decode of the state register, never of src_valid.
  assign src_ready = (r_state == LOAD);
  assign w_hs      = src_valid & src_ready;
  assign w_final   = (r_fc == VW'(r_od)) && (r_ac == r_fs_eff);
  assign w_unused  = ^src_data[15:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_od     <= '0;
      r_fs_eff <= '0;
      r_fc     <= '0;
      r_ac     <= '0;
      r_err    <= 1'b0;
      r_done   <= 1'b0;
      r_we     <= 1'b0;
      r_v      <= '0;
      r_a      <= '0;
      r_d      <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_od     <= w_od_nxt;
      r_fs_eff <= w_fs_eff_nxt;
      r_fc     <= w_fc_nxt;
      r_ac     <= w_ac_nxt;
      r_err    <= w_err_nxt;
      r_done   <= w_done_nxt;
      r_we     <= w_we_nxt;
      r_v      <= w_v_nxt;
      r_a      <= w_a_nxt;
      r_d      <= w_d_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_od_nxt     = r_od;
    w_fs_eff_nxt = r_fs_eff;
    w_fc_nxt     = r_fc;
    w_ac_nxt     = r_ac;
    w_err_nxt    = r_err;
    w_done_nxt   = 1'b0;
    w_we_nxt     = 1'b0;
    w_v_nxt      = r_v;
    w_a_nxt      = r_a;
    w_d_nxt      = r_d;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt  = LOAD;
          w_od_nxt     = od;
          w_fs_eff_nxt = bmode ? '0 : fs;
          w_fc_nxt     = '0;
          w_ac_nxt     = '0;
          w_err_nxt    = 1'b0;
        end
      end
      LOAD: begin
        if (w_hs) begin
          w_we_nxt = 1'b1;
          w_v_nxt  = r_fc;
          w_a_nxt  = r_ac;
          w_d_nxt  = src_data[31:16];
          if (r_ac == r_fs_eff) begin
            w_ac_nxt = '0;
            w_fc_nxt = r_fc + 1'b1;
          end else begin
            w_ac_nxt = r_ac + 1'b1;
          end
          // Final word without last is a late-last error; last before final truncates.
          if (w_final) begin
            w_state_nxt = DRAIN;
            if (!src_last) w_err_nxt = 1'b1;
          end else if (src_last) begin
            w_state_nxt = DRAIN;
            w_err_nxt   = 1'b1;
          end
        end
      end
      DRAIN: begin
        w_state_nxt = IDLE;
        w_done_nxt  = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign prm_we    = r_we;
  assign prm_v     = r_v;
  assign prm_a     = r_a;
  assign prm_d     = r_d;
  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_prm_load_seq.sv
// Directed bench for prm_load_seq: framing cases, bias/weight walks, reset and ignored starts.
module tb_prm_load_seq;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst, start, bmode, src_valid, src_last;
  logic [3:0]    od;
  logic [AW-1:0] fs;
  logic [31:0]   src_data;
  logic          src_ready, prm_we, busy, done, err;
  logic [3:0]    prm_v;
  logic [AW-1:0] prm_a;
  logic [15:0]   prm_d;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // write record = {v, a, d}
  logic [29:0] exp_q[$];
  logic [29:0] obs_q[$];

  prm_load_seq #(.f_num(16), .AW(AW), .DW(16)) dut (
    .clk(clk), .rst(rst), .start(start), .bmode(bmode), .od(od), .fs(fs),
    .src_valid(src_valid), .src_data(src_data), .src_last(src_last),
    .src_ready(src_ready), .prm_we(prm_we), .prm_v(prm_v), .prm_a(prm_a),
    .prm_d(prm_d), .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (prm_we) obs_q.push_back({prm_v, prm_a, prm_d});

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic b, input logic [3:0] o, input logic [AW-1:0] f);
    bmode = b; od = o; fs = f; start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [15:0] d, input logic last, input int gap);
    for (int g = 0; g < gap; g++) begin
      src_valid = 1'b0;
      tick;
    end
    src_valid = 1'b1;
    src_data  = {d, 16'($urandom)};
    src_last  = last;
    tick;
    src_valid = 1'b0;
    src_last  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic exp_err);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick;
      seen = done;
    end
    chk({tag, "_done"}, 32'(seen), 32'd1);
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic cmp_writes(input string tag);
    chk({tag, "_nwr"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk($sformatf("%s_wr%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    logic [15:0] d;
    rst = 1'b1; start = 1'b0; bmode = 1'b0; od = '0; fs = '0;
    src_valid = 1'b0; src_data = '0; src_last = 1'b0;
    repeat (3) tick;
    chk("rst_ready", 32'(src_ready), 0);
    chk("rst_we", 32'(prm_we), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_state", 32'(dbg_state), 0);
    rst = 1'b0;
    tick;
    obs_q.delete();

    // Weight load od=1 fs=2, valid held, per-cycle timing check
    do_start(1'b0, 4'd1, 10'd2);
    chk("w_busy", 32'(busy), 1);
    chk("w_ready", 32'(src_ready), 1);
    for (int i = 0; i < 6; i++) begin
      src_valid = 1'b1;
      src_data  = {16'hA000 + 16'(i), 16'h5A5A};
      src_last  = (i == 5);
      tick;
      chk($sformatf("w_we%0d", i), 32'(prm_we), 1);
      chk($sformatf("w_va%0d", i), {prm_v, 18'(prm_a)}, {4'(i / 3), 18'(i % 3)});
      chk($sformatf("w_d%0d", i), 32'(prm_d), 32'(16'hA000 + 16'(i)));
    end
    src_valid = 1'b0; src_last = 1'b0;
    chk("w_drain_ready", 32'(src_ready), 0);
    chk("w_drain_done", 32'(done), 0);
    tick;
    chk("w_done", 32'(done), 1);
    chk("w_busy_end", 32'(busy), 0);
    chk("w_we_end", 32'(prm_we), 0);
    chk("w_err", 32'(err), 0);
    tick;
    chk("w_done_pulse", 32'(done), 0);
    obs_q.delete();

    // Bias load od=15 with random gaps; fs must be ignored
    do_start(1'b1, 4'd15, 10'h3FF);
    for (int i = 0; i < 16; i++) begin
      d = 16'($urandom);
      exp_q.push_back({4'(i), 10'd0, d});
      send_beat(d, i == 15, $urandom_range(0, 3));
    end
    wait_done("b", 1'b0);
    cmp_writes("b");

    // Early last: od=0 fs=3, last on 2nd word; start in DRAIN ignored
    do_start(1'b0, 4'd0, 10'd3);
    exp_q.push_back({4'd0, 10'd0, 16'h1111});
    exp_q.push_back({4'd0, 10'd1, 16'h2222});
    send_beat(16'h1111, 1'b0, 0);
    send_beat(16'h2222, 1'b1, 1);
    chk("e_err_drain", 32'(err), 1);
    od = 4'd5; fs = 10'd7; start = 1'b1;
    tick;
    start = 1'b0;
    chk("e_done", 32'(done), 1);
    chk("e_state", 32'(dbg_state), 0);
    chk("e_err_kept", 32'(err), 1);
    cmp_writes("e");

    // Late last: od=0 fs=1; the start also clears err
    do_start(1'b0, 4'd0, 10'd1);
    chk("l_err_clr", 32'(err), 0);
    exp_q.push_back({4'd0, 10'd0, 16'h3333});
    exp_q.push_back({4'd0, 10'd1, 16'h4444});
    send_beat(16'h3333, 1'b0, 0);
    send_beat(16'h4444, 1'b0, 0);
    chk("l_ready", 32'(src_ready), 0);
    chk("l_err", 32'(err), 1);
    src_valid = 1'b1; src_data = 32'h5555_0000;
    tick;
    chk("l_done", 32'(done), 1);
    tick;
    chk("l_ready_idle", 32'(src_ready), 0);
    src_valid = 1'b0;
    tick;
    cmp_writes("l");

    // Reset mid-load after 3 handshakes
    do_start(1'b0, 4'd1, 10'd3);
    send_beat(16'h6001, 1'b0, 0);
    send_beat(16'h6002, 1'b0, 0);
    send_beat(16'h6003, 1'b0, 0);
    chk("r_we_pre", 32'(prm_we), 1);
    rst = 1'b1; src_valid = 1'b1; src_data = 32'h6004_0000;
    tick;
    rst = 1'b0; src_valid = 1'b0;
    chk("r_we", 32'(prm_we), 0);
    chk("r_va", {prm_v, 18'(prm_a)}, 0);
    chk("r_d", 32'(prm_d), 0);
    chk("r_busy", 32'(busy), 0);
    chk("r_ready", 32'(src_ready), 0);
    chk("r_done_err", {done, err}, 0);
    chk("r_state", 32'(dbg_state), 0);
    obs_q.delete();
    do_start(1'b0, 4'd0, 10'd0);
    exp_q.push_back({4'd0, 10'd0, 16'h7777});
    send_beat(16'h7777, 1'b1, 0);
    wait_done("s", 1'b0);
    cmp_writes("s");

    // Start during LOAD and DRAIN is ignored
    do_start(1'b0, 4'd0, 10'd2);
    exp_q.push_back({4'd0, 10'd0, 16'h8000});
    exp_q.push_back({4'd0, 10'd1, 16'h8001});
    exp_q.push_back({4'd0, 10'd2, 16'h8002});
    send_beat(16'h8000, 1'b0, 0);
    od = 4'd3; fs = 10'd9; start = 1'b1;
    send_beat(16'h8001, 1'b0, 0);
    start = 1'b0;
    send_beat(16'h8002, 1'b1, 0);
    chk("i_state_drain", 32'(dbg_state), 2);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("i_done", 32'(done), 1);
    chk("i_busy", 32'(busy), 0);
    chk("i_err", 32'(err), 0);
    cmp_writes("i");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/prm_load_seq.md
Name: prm_load_seq

Overview:
- Sequences weight and bias loading from the input AXI-stream into the f_num tiny_dnn_core parameter memories.
- Walks the stream filter-major: for each filter f = 0..od, for each address a = 0..fs.
- Produces a registered, one-cycle-delayed write strobe, a core select, a core-local address and a data word.
- Checks stream framing against the programmed geometry and reports completion or error.

Parameters:
- f_num, 16, number of cores; od must be < f_num.
- AW, 10, parameter-memory address width.
- DW, 16, parameter word width, taken from src_data[31:16].

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a load, ignored unless IDLE
- bmode  in  1  sampled at start; 1 = bias load (one word per filter), 0 = weight load
- od  in  4  filter count minus 1, sampled at start
- fs  in  AW  words per filter minus 1, sampled at start; ignored when bmode=1
- src_valid  in  1  stream valid
- src_data  in  32  stream data
- src_last  in  1  stream last
- src_ready  out  1  stream ready
- prm_we  out  1  registered write strobe to the selected core
- prm_v  out  4  registered core select
- prm_a  out  AW  registered core-local address
- prm_d  out  DW  registered write data
- busy  out  1  high in LOAD and DRAIN
- done  out  1  one-cycle pulse at completion
- err  out  1  sticky framing error, cleared by start or rst

Behaviour:
- Reset values: src_ready=0, prm_we=0, prm_v=0, prm_a=0, prm_d=0, busy=0, done=0, err=0, state=IDLE, counters=0.
- rst overrides everything, including mid-load. The in-flight write is dropped: prm_we=0 in the next cycle.
- States:
  - IDLE:
    - src_ready=0.
    - start → LOAD. Latch od, fs_eff (fs_eff = 0 if bmode, else fs) and bmode. Clear fc, ac and err.
  - LOAD:
    - src_ready=1.
    - Handshake hs = src_valid & src_ready.
    - On hs, the next cycle has prm_we=1, prm_v=fc, prm_a=ac, prm_d=src_data[31:16]. Latency is exactly 1 cycle.
    - Without hs, prm_we=0 next cycle; prm_v, prm_a and prm_d hold.
    - Counter update on hs:
      - if ac==fs_eff then ac←0 and fc←fc+1;
      - else ac←ac+1.
    - Final word = hs with fc==od and ac==fs_eff:
      - src_last=1 → DRAIN.
      - src_last=0 → DRAIN with err←1 (late last).
    - hs with src_last=1 before the final word:
      - the word is written, err←1, → DRAIN (early last, load truncated).
  - DRAIN:
    - src_ready=0.
    - Lasts one cycle, so the final prm_we issues.
    - Then → IDLE with done=1 for that one cycle; busy=0 from the IDLE cycle onward.
- start outside IDLE is ignored and does not clear err.
- Counters are never compared beyond fs_eff and od, so there is no wrap. ac and fc are AW and 4 bits wide.
- Bias mode: prm_a is always 0 and there are od+1 words in total.
- src_ready depends only on the state register and is never combinational on src_valid.
- Total accepted words in a clean load: (od+1)*(fs_eff+1).
- Boundary od=0, fs=0 (single word): LOAD accepts exactly one word, then DRAIN, then done.

Test Plan:
- Weight load od=1, fs=2, valid held high, last on the 6th word → prm_we pulses 6 cycles with (v,a) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2), each one cycle after its handshake; done 2 cycles after the last handshake; err=0.
- Bias load bmode=1, od=15 with random valid gaps → 16 writes with v=0..15, a=0; prm_d equals src_data[31:16] of each accepted beat; no write in gap cycles.
- Early last: od=0, fs=3, last on the 2nd word → writes a=0,1 only; err=1; done pulses; state returns to IDLE; next start clears err.
- Late last: od=0, fs=1, no last on the 2nd word → 2 writes, err=1, src_ready=0 afterwards; a 3rd offered beat is not accepted.
- rst asserted mid-load after 3 handshakes → next cycle all outputs at reset values; a subsequent start with od=0, fs=0 completes a single write at (0,0).
- start pulsed during LOAD and during DRAIN → ignored; counters, err and the write sequence are unaffected.
